demo_song_player: RTL and testbench

Autonomous song sequencer that drives the live-key interface (4-bit key ID plus key-pressed level) that practice-mode checking and tone generation consume. It is the producer end of that interface. It plays the built-in 14-note practice tune with per-note durations and a mandatory release gap between notes. The gap guarantees a fresh rising edge of `key_pressed` for every note, including repeated notes. It sits beside the physical keypad and is muxed onto the live-key bus when demo mode is selected.

---
 rtl/demo_song_player.sv | 126 ++++++++++++
 tb/tb_demo_song_player.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/demo_song_player.sv
// Autonomous 14-note practice-tune sequencer driving the live-key bus.
// Each note sounds for its beat count, then releases for a fixed gap.
module demo_song_player #(
  parameter int TICKS_PER_BEAT = 12_500_000,
  parameter int GAP_TICKS      = 1_250_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       play_start,
  input  logic       play_stop,
  input  logic       loop_enable,
  output logic [3:0] key_id,
  output logic       key_pressed,
  output logic [3:0] note_index,
  output logic       playing,
  output logic       song_finished_event
);

  // The gap load shares this counter, so GAP_TICKS is expected to be <= 2*TICKS_PER_BEAT.
  localparam int CW = $clog2(2 * TICKS_PER_BEAT + 1);
  localparam logic [3:0]    LAST_IDX = 4'd13;
  localparam logic [CW-1:0] LOAD_1B  = CW'(TICKS_PER_BEAT - 1);
  localparam logic [CW-1:0] LOAD_2B  = CW'(2 * TICKS_PER_BEAT - 1);
  localparam logic [CW-1:0] LOAD_GAP = CW'(GAP_TICKS - 1);

  typedef enum logic [1:0] {IDLE, NOTE_ON, GAP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    idx, idx_n;
  logic          fin_n;

  // NOTE: the song ROM is a constant case table, not storage, so it needs no reset.
  function automatic logic [3:0] rom_note(input logic [3:0] i);
    case (i)
      4'd0, 4'd1, 4'd13:  rom_note = 4'd1;
      4'd2, 4'd3, 4'd6:   rom_note = 4'd5;
      4'd4, 4'd5:         rom_note = 4'd6;
      4'd7, 4'd8:         rom_note = 4'd4;
      4'd9, 4'd10:        rom_note = 4'd3;
      4'd11, 4'd12:       rom_note = 4'd2;
      default:            rom_note = 4'd0;
    endcase
  endfunction

  // Counter counts down to zero, so the load is duration minus one.
  function automatic logic [CW-1:0] note_load(input logic [3:0] i);
    note_load = (i == 4'd6 || i == 4'd13) ? LOAD_2B : LOAD_1B;
  endfunction

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    fin_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (play_start && !play_stop) begin
          state_n = NOTE_ON;
          idx_n   = 4'd0;
          cnt_n   = note_load(4'd0);
        end
      end
      NOTE_ON: begin
        if (play_stop) begin
          state_n = IDLE;
        end else if (cnt == '0) begin
          state_n = GAP;
          cnt_n   = LOAD_GAP;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      GAP: begin
        if (play_stop) begin
          state_n = IDLE;
        end else if (cnt == '0) begin
          if (idx < LAST_IDX) begin
            state_n = NOTE_ON;
            idx_n   = idx + 4'd1;
            cnt_n   = note_load(idx + 4'd1);
          end else if (loop_enable) begin
            state_n = NOTE_ON;
            idx_n   = 4'd0;
            cnt_n   = note_load(4'd0);
          end else begin
            state_n = IDLE;
            fin_n   = 1'b1;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    if (state_n == IDLE) begin
      idx_n = 4'd0;
      cnt_n = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      cnt                 <= '0;
      idx                 <= 4'd0;
      key_id              <= 4'd0;
      key_pressed         <= 1'b0;
      note_index          <= 4'd0;
      playing             <= 1'b0;
      song_finished_event <= 1'b0;
    end else begin
      state               <= state_n;
      cnt                 <= cnt_n;
      idx                 <= idx_n;
      key_id              <= (state_n == NOTE_ON) ? rom_note(idx_n) : 4'd0;
      key_pressed         <= (state_n == NOTE_ON);
      note_index          <= idx_n;
      playing             <= (state_n != IDLE);
      song_finished_event <= fin_n;
    end
  end

endmodule

// File: tb/tb_demo_song_player.sv
// Scoreboard bench: a timeline model predicts every output cycle, a monitor
// compares DUT outputs against the queued predictions on the falling edge.
module tb_demo_song_player;

  localparam int TPB      = 4;
  localparam int GAPT     = 2;
  localparam int N        = 14;
  localparam int SONG_LEN = 16 * TPB + N * GAPT;

  int notes[N] = '{1, 1, 5, 5, 6, 6, 5, 4, 4, 3, 3, 2, 2, 1};
  int beats[N] = '{1, 1, 1, 1, 1, 1, 2, 1, 1, 1, 1, 1, 1, 2};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       play_start = 1'b0;
  logic       play_stop = 1'b0;
  logic       loop_enable = 1'b0;
  logic [3:0] key_id;
  logic       key_pressed;
  logic [3:0] note_index;
  logic       playing;
  logic       song_finished_event;

  always #5 clk = ~clk;

  demo_song_player #(.TICKS_PER_BEAT(TPB), .GAP_TICKS(GAPT)) dut (
    .clk(clk), .rst(rst), .play_start(play_start), .play_stop(play_stop),
    .loop_enable(loop_enable), .key_id(key_id), .key_pressed(key_pressed),
    .note_index(note_index), .playing(playing),
    .song_finished_event(song_finished_event)
  );

  typedef struct {
    logic [3:0] key_id;
    logic       key_pressed;
    logic [3:0] note_index;
    logic       playing;
    logic       fin;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: song is a timeline of SONG_LEN cycles; m_t is the offset of the current cycle.
  bit m_active = 0;
  int m_t      = 0;
  bit m_fin    = 0;

  function automatic exp_t model_out();
    exp_t e;
    int   t;
    e = '{4'd0, 1'b0, 4'd0, 1'b0, m_fin};
    if (m_active) begin
      t = m_t;
      e.playing = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (t >= 0 && t < beats[i] * TPB) begin
          e.key_id = 4'(notes[i]); e.key_pressed = 1'b1; e.note_index = 4'(i);
        end else if (t >= beats[i] * TPB && t < beats[i] * TPB + GAPT) begin
          e.note_index = 4'(i);
        end
        t -= beats[i] * TPB + GAPT;
      end
    end
    return e;
  endfunction

  function automatic void model_step(input bit s, input bit p, input bit l, input bit r);
    m_fin = 0;
    if (r) begin
      m_active = 0;
    end else if (m_active) begin
      if (p) m_active = 0;
      else if (m_t == SONG_LEN - 1) begin
        if (l) m_t = 0;
        else begin m_active = 0; m_fin = 1; end
      end else m_t++;
    end else if (s && !p) begin
      m_active = 1;
      m_t = 0;
    end
  endfunction

  bit loop_lvl = 0;

  task automatic step(input bit s, input bit p, input bit r);
    play_start  = s;
    play_stop   = p;
    loop_enable = loop_lvl;
    rst         = r;
    model_step(s, p, loop_lvl, r);
    q.push_back(model_out());
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  // Monitor: compares every presented cycle and tracks edges for song-level checks.
  int   cyc = 0, rises = 0, finishes = 0, start_cyc = 0, last_lat = -1;
  logic prev_kp = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("key_id", 32'(key_id), 32'(e.key_id));
      check("key_pressed", 32'(key_pressed), 32'(e.key_pressed));
      check("note_index", 32'(note_index), 32'(e.note_index));
      check("playing", 32'(playing), 32'(e.playing));
      check("song_finished_event", 32'(song_finished_event), 32'(e.fin));
      if (key_pressed === 1'b1 && prev_kp !== 1'b1) begin
        rises++;
        if (note_index === 4'd0) start_cyc = cyc;
      end
      if (song_finished_event === 1'b1) begin
        finishes++;
        last_lat = cyc - start_cyc;
      end
      prev_kp = key_pressed;
    end
  end

  int r0, f0;

  initial begin
    // Reset, then one full song without loop.
    step(0, 0, 1); step(0, 0, 1); step(0, 0, 1);
    idle(4);
    r0 = rises; f0 = finishes;
    step(1, 0, 0);
    idle(100);
    check("full_song_rises", 32'(rises - r0), 32'd14);
    check("full_song_finish_count", 32'(finishes - f0), 32'd1);
    check("full_song_latency", 32'(last_lat), 32'(SONG_LEN));

    // Loop held through one wrap, then dropped before the next end.
    f0 = finishes; loop_lvl = 1;
    step(1, 0, 0);
    idle(150);
    loop_lvl = 0;
    idle(60);
    check("loop_finish_count", 32'(finishes - f0), 32'd1);
    check("loop_latency", 32'(last_lat), 32'(SONG_LEN));

    // Stop during note 6, then restart from note 0.
    f0 = finishes;
    step(1, 0, 0);
    idle(38);
    step(0, 1, 0);
    idle(5);
    check("stop_no_finish", 32'(finishes - f0), 32'd0);
    step(1, 0, 0);
    idle(10);
    step(0, 1, 0);
    idle(3);

    // Start+stop together in idle; start mid-song is ignored.
    step(1, 1, 0);
    idle(3);
    step(1, 0, 0);
    idle(10);
    step(1, 0, 0);
    idle(5);
    step(0, 1, 0);
    idle(2);

    // Reset during the first gap.
    step(1, 0, 0);
    idle(4);
    step(0, 0, 1);
    idle(5);
    step(1, 0, 0);
    idle(5);
    step(0, 1, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) loop_lvl = ~loop_lvl;
      step($urandom_range(0, 39) == 0, $urandom_range(0, 199) == 0,
           $urandom_range(0, 499) == 0);
    end
    idle(2);
    #20;
    check("queue_drain", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
